// File: rtl/my_aes_pkg.sv
// rtl/my_aes_pkg.sv - shared AES-128 constants, state encoding and key-schedule helper functions
package my_aes_pkg;

  localparam logic [3:0] AES128_ROUNDS = 4'ha;
  localparam int         ROUND_W       = 4;

  typedef enum logic {
    STATE_IDLE = 1'b0,
    STATE_EXP  = 1'b1
  } state_t;

  // Forward S-box, entry 0 in the leftmost byte so SBOX_TABLE[x] is S(x).
  localparam logic [0:255][7:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Round constant for key-schedule round 1..10; zero outside that range.
  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] rc;
    case (round)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // Cyclic left rotation of a word by one byte.
  function automatic logic [31:0] rotword(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Single-byte S-box lookup.
  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX_TABLE[b];
  endfunction

  // S-box applied to each byte of a word.
  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
  endfunction

endpackage

// File: rtl/my_aes_sbox.sv
// rtl/my_aes_sbox.sv - combinational 8-bit AES forward S-box
module my_aes_sbox
  import my_aes_pkg::*;
(
  input  logic [7:0] data,
  output logic [7:0] sub
);

  assign sub = sub_byte(data);

endmodule

// File: rtl/my_aes_key_expand.sv
// rtl/my_aes_key_expand.sv - AES-128 round-key streamer, optional AES_KEY_EXPAND_STALL_EN adds rk_ready back-pressure
module my_aes_key_expand
  import my_aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               key_start,
  input  logic [127:0]       key,
  output logic               ready,
`ifdef AES_KEY_EXPAND_STALL_EN
  input  logic               rk_ready,
`endif
  output logic [ROUND_W-1:0] rk_round,
  output logic [127:0]       rk_key,
  output logic               rk_valid,
  output logic               done
);

  state_t       state;
  state_t       state_nxt;
  logic         advance;
  logic         last_round;
  logic [31:0]  rot_w3;
  logic [31:0]  sub_w3;
  logic [31:0]  t_word;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] next_key;

  // A round moves on only when the consumer takes it; without back-pressure every valid cycle counts.
`ifdef AES_KEY_EXPAND_STALL_EN
  assign advance = rk_valid & rk_ready;
`else
  assign advance = rk_valid;
`endif

  assign last_round = (rk_round == AES128_ROUNDS);

  // One SubWord per round: four S-boxes on the rotated last word.
  assign rot_w3 = rotword(rk_key[31:0]);

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    my_aes_sbox u_sbox (
      .data (rot_w3[8*i +: 8]),
      .sub  (sub_w3[8*i +: 8])
    );
  end

  // rk_round is never past 10 here, so rk_round+1 cannot wrap.
  assign t_word   = sub_w3 ^ {rcon(rk_round + 4'd1), 24'h0};
  assign n0       = rk_key[127:96] ^ t_word;
  assign n1       = rk_key[95:64]  ^ n0;
  assign n2       = rk_key[63:32]  ^ n1;
  assign n3       = rk_key[31:0]   ^ n2;
  assign next_key = {n0, n1, n2, n3};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= STATE_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and ready.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    case (state)
      STATE_IDLE: begin
        ready = 1'b1;
        if (key_start) begin
          state_nxt = STATE_EXP;
        end
      end
      STATE_EXP: begin
        if (advance && last_round) begin
          state_nxt = STATE_IDLE;
        end
      end
      default: begin
        state_nxt = STATE_IDLE;
      end
    endcase
  end

  // Round-key stream registers and the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rk_round <= '0;
      rk_key   <= '0;
      rk_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        STATE_IDLE: begin
          if (key_start) begin
            rk_round <= '0;
            rk_key   <= key;
            rk_valid <= 1'b1;
          end
        end
        STATE_EXP: begin
          if (advance) begin
            if (last_round) begin
              rk_valid <= 1'b0;
              done     <= 1'b1;
            end else begin
              rk_key   <= next_key;
              rk_round <= rk_round + 4'd1;
            end
          end
        end
        default: begin
          rk_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_my_aes_key_expand.sv
// tb/tb_my_aes_key_expand.sv - self-checking bench for my_aes_key_expand against a GF(2^8) key-schedule model
module tb_my_aes_key_expand;

  logic         clk;
  logic         rst;
  logic         key_start;
  logic [127:0] key;
  logic         ready;
  logic         rk_ready;
  logic [3:0]   rk_round;
  logic [127:0] rk_key;
  logic         rk_valid;
  logic         done;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox_m [256];
  logic [127:0] known [11];
  bit           known_v [11];

  my_aes_key_expand dut (
    .clk       (clk),
    .rst       (rst),
    .key_start (key_start),
    .key       (key),
    .ready     (ready),
`ifdef AES_KEY_EXPAND_STALL_EN
    .rk_ready  (rk_ready),
`endif
    .rk_round  (rk_round),
    .rk_key    (rk_key),
    .rk_valid  (rk_valid),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse then the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] model_subw(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  // Word-by-word key expansion with rcon generated by repeated doubling.
  task automatic model_expand(input logic [127:0] k, output logic [127:0] rk [11]);
    logic [31:0] w [44];
    logic [31:0] temp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = model_subw({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Start an expansion in the current cycle T and follow it cycle by cycle.
  // glitch_r: pulse key_start while round glitch_r is shown; rst_r: reset while round rst_r is shown;
  // stall_r/stall_n: hold rk_ready low for stall_n cycles at round stall_r.
  task automatic run_exp(input logic [127:0] k, input int glitch_r, input int rst_r,
                         input int stall_r, input int stall_n);
    logic [127:0] rk [11];
    model_expand(k, rk);
    check("idle_ready", ready, 1);
    key_start = 1'b1;
    key = k;
    tick();
    key_start = 1'b0;
    key = {$urandom, $urandom, $urandom, $urandom};
    for (int r = 0; r < 11; r++) begin
      check($sformatf("valid_r%0d", r), rk_valid, 1);
      check($sformatf("round_r%0d", r), rk_round, 128'(r));
      check($sformatf("key_r%0d", r), rk_key, rk[r]);
      check($sformatf("busy_r%0d", r), ready, 0);
      check($sformatf("nodone_r%0d", r), done, 0);
      if (known_v[r]) check($sformatf("vector_r%0d", r), rk_key, known[r]);
`ifdef AES_KEY_EXPAND_STALL_EN
      if (r == stall_r) begin
        rk_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          tick();
          check($sformatf("stall_round_r%0d", r), rk_round, 128'(r));
          check($sformatf("stall_key_r%0d", r), rk_key, rk[r]);
          check($sformatf("stall_valid_r%0d", r), rk_valid, 1);
        end
        rk_ready = 1'b1;
      end
`endif
      if (r == glitch_r) begin
        key_start = 1'b1;
      end
      if (r == rst_r) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_valid", rk_valid, 0);
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_round", rk_round, 0);
        check("rst_key", rk_key, 0);
        for (int i = 0; i < 11; i++) known_v[i] = 1'b0;
        return;
      end
      tick();
      key_start = 1'b0;
    end
    check("end_valid", rk_valid, 0);
    check("end_done", done, 1);
    check("end_ready", ready, 1);
    for (int i = 0; i < 11; i++) known_v[i] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    key_start = 1'b0;
    key = '0;
    rk_ready = 1'b1;
    for (int i = 0; i < 11; i++) known_v[i] = 1'b0;
    build_sbox();
    tick();
    key_start = 1'b1;
    key = {128{1'b1}};
    tick();
    key_start = 1'b0;
    check("reset_valid", rk_valid, 0);
    check("reset_done", done, 0);
    check("reset_round", rk_round, 0);
    check("reset_key", rk_key, 0);
    check("reset_ready", ready, 1);
    rst = 1'b0;
    tick();
    check("post_reset_valid", rk_valid, 0);

    // FIPS-197 key.
    known[0] = 128'h2b7e151628aed2a6abf7158809cf4f3c;  known_v[0] = 1'b1;
    known[1] = 128'ha0fafe1788542cb123a339392a6c7605;  known_v[1] = 1'b1;
    known[2] = 128'hf2c295f27a96b9435935807a7359f67f;  known_v[2] = 1'b1;
    known[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6; known_v[10] = 1'b1;
    run_exp(128'h2b7e151628aed2a6abf7158809cf4f3c, -1, -1, -1, 0);
    tick();
    check("done_one_cycle", done, 0);
    check("idle_no_valid", rk_valid, 0);

    // All-zero key.
    known[1] = 128'h62636363626363636263636362636363;  known_v[1] = 1'b1;
    known[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e; known_v[10] = 1'b1;
    run_exp(128'h0, -1, -1, -1, 0);
    tick();

    // key_start while busy (cycle T+5) is ignored.
    run_exp({$urandom, $urandom, $urandom, $urandom}, 4, -1, -1, 0);
    tick();
    check("glitch_no_restart", rk_valid, 0);

    // Reset during expansion (cycle T+6), then a fresh request at T+8.
    run_exp({$urandom, $urandom, $urandom, $urandom}, -1, 5, -1, 0);
    tick();
    check("rst_no_late_done", done, 0);
    run_exp({$urandom, $urandom, $urandom, $urandom}, -1, -1, -1, 0);
    tick();

    // Back-to-back: second request in the done cycle.
    run_exp({$urandom, $urandom, $urandom, $urandom}, -1, -1, -1, 0);
    run_exp({$urandom, $urandom, $urandom, $urandom}, -1, -1, -1, 0);
    tick();
    check("b2b_done_low", done, 0);

`ifdef AES_KEY_EXPAND_STALL_EN
    // Three stall cycles at round 4.
    run_exp({$urandom, $urandom, $urandom, $urandom}, -1, -1, 4, 3);
    tick();
`endif

    // Randomized keys.
    for (int n = 0; n < 4; n++) begin
      run_exp({$urandom, $urandom, $urandom, $urandom}, -1, -1, -1, 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/my_aes_key_expand.md
Name: my_aes_key_expand

Overview:
AES-128 key-schedule stage sitting directly upstream of the encipher core. It accepts one 128-bit cipher key and computes round keys 0..10, one per cycle. Each round key is streamed out on a round-indexed write port (round number, 128-bit key, valid strobe), which loads the encipher's round-key memory. Only one 32-bit SubWord is computed per round.

Parameters:
AES128_ROUNDS, 4'ha, index of the last round key produced; fixed for AES-128, not intended to be overridden.
ROUND_W, 4, width of the round index output.

Ports:
clk  input  1  single clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
key_start  input  1  single-cycle request to expand `key`; accepted only when ready=1.
key  input  128  cipher key, sampled in the accept cycle only.
ready  output  1  high in IDLE; block can accept key_start.
rk_round  output  4  round index of rk_key (0..10).
rk_key  output  128  round key for rk_round, FIPS-197 word order (w[4r] in bits 127:96).
rk_valid  output  1  rk_round/rk_key are valid this cycle; maps onto the encipher's init_round / init_roundkey / init_roundkey_valid.
done  output  1  one-cycle pulse after round 10 has been emitted.

Behaviour:
- Reset values (on rst=1 at posedge):
  - state=IDLE, ready=1, rk_valid=0, done=0, rk_round=0, rk_key=0.
- FSM states:
  - IDLE: ready=1. On key_start=1, latch key into key_reg, set rk_round=0, rk_key=key, rk_valid=1, and go to EXPAND.
  - EXPAND: each cycle, if rk_round < AES128_ROUNDS:
    - rk_key <= next_key(rk_key, rcon[rk_round+1]);
    - rk_round <= rk_round+1;
    - rk_valid stays 1.
  - EXPAND, when rk_round == AES128_ROUNDS: rk_valid <= 0, done <= 1, go to IDLE with ready=1.
- Latency: key_start accepted at cycle T → round r valid at T+1+r (r=0..10), done at T+12, ready=1 again at T+12.
  - New key_start is accepted in cycle T+12, which gives back-to-back expansions every 12 cycles.
- next_key: let w0..w3 be the current words.
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}.
  - n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2.
- Rcon for rounds 1..10: 01,02,04,08,10,20,40,80,1b,36 (8-bit, MSB byte of word).
- key_start while ready=0: ignored; no queuing, no effect on the current expansion.
- key_start and rst in the same cycle: rst wins, request is dropped.
- rst during EXPAND: next cycle rk_valid=0, done=0, state IDLE; the partial key sequence is abandoned and done is never pulsed.
- done and rk_valid are never high in the same cycle.
- rk_round never exceeds AES128_ROUNDS; there is no wrap to 11–15.

Optional Feature:
AES_KEY_EXPAND_STALL_EN
- With the macro: adds input port rk_ready (1 bit).
  - In EXPAND, a round advances only when rk_valid & rk_ready.
  - rk_round and rk_key are held stable while rk_ready=0.
  - The final handshake (round 10 accepted) triggers done on the next cycle.
  - Latency becomes 12 cycles plus the number of stall cycles.
- Without the macro: no rk_ready port; the stream is uninterrupted, exactly as described in Behaviour.

Decomposition:
- Shared package my_aes_pkg:
  - AES128_ROUNDS constant;
  - state encodings STATE_IDLE / STATE_EXP;
  - rcon lookup function;
  - rotword / subword helper functions.
- Sub-module my_aes_sbox: combinational 8-bit forward S-box. Instantiated 4× for SubWord; the same module is reusable by the encipher.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c → rounds 0, 1, 2, 10 give:
  - r0 = 2b7e151628aed2a6abf7158809cf4f3c;
  - r1 = a0fafe1788542cb123a339392a6c7605;
  - r2 = f2c295f27a96b9435935807a7359f67f;
  - r10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - rk_valid high for exactly 11 consecutive cycles; done at T+12.
- All-zero key → r1 = 62636363626363636263636362636363; r10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- key_start pulsed at T+5 during an expansion → ignored; sequence and done timing unchanged; ready=0 from T+1 to T+11.
- rst asserted at T+6 → at T+7 rk_valid=0, ready=1, and no done pulse. A new key_start at T+8 then produces a full correct sequence.
- Back-to-back requests: key_start at T and T+12 → two full 11-key streams with a one-cycle gap, two done pulses.
- With AES_KEY_EXPAND_STALL_EN, hold rk_ready=0 for 3 cycles at round 4 → rk_round=4 and rk_key held, then sequence resumes; done at T+15.
